// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the fetched word and its PC into IF/ID, squashing it on EX redirects.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pc_enable,
    input  logic             load_enable,
    input  logic             redirect,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      if_id_instruction,
    output logic [31:0]      if_id_pc,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        state_d = ST_RUN;
        pc_d    = pc_q;
        instr_d = instr_q;
        id_pc_d = id_pc_q;
        valid_d = valid_q;
        count_d = count_q;

        if (state_q == ST_RUN) begin
            // A resolved branch in EX outranks any stall: the younger ID word is squashed.
            if (redirect) begin
                pc_d    = redirect_target & 32'hFFFF_FFFC;
                instr_d = NOP_INSTR;
                id_pc_d = pc_q;
                valid_d = 1'b0;
            end else begin
                if (pc_enable) begin
                    pc_d = pc_q + 32'd4;
                end
                if (load_enable) begin
                    instr_d = imem_data;
                    id_pc_d = pc_q;
                    valid_d = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            id_pc_q <= RESET_PC;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            id_pc_q <= id_pc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign imem_addr         = pc_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc          = id_pc_q;
    assign if_id_valid       = valid_q;
    assign fetch_count       = count_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: a reference model pushes the expected
// IF/ID state per cycle, which is popped and compared one edge later.
module tb_if_id_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pc_enable, load_enable, redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] if_id_instruction, if_id_pc;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] id_pc;
        logic        valid;
        logic [31:0] count;
    } exp_t;

    exp_t sb_q[$];

    // bench-side model state
    logic [31:0] m_pc, m_instr, m_id_pc, m_count;
    logic        m_valid;

    always #5 clk = ~clk;

    if_id_fetch_stage dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pc_enable         (pc_enable),
        .load_enable       (load_enable),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_valid       (if_id_valid),
        .fetch_count       (fetch_count)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return {a[21:2], 12'h093} ^ 32'h1357_9000;
    endfunction

    assign imem_data = imem_word(imem_addr);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Drive one cycle of stimulus, predict the result, then compare after the edge.
    task automatic step(input logic pe, input logic le, input logic rd, input logic [31:0] tgt);
        exp_t e;
        exp_t o;
        @(negedge clk);
        pc_enable = pe; load_enable = le; redirect = rd; redirect_target = tgt;
        check_val("imem_addr", imem_addr, m_pc);
        if (rd) begin
            m_id_pc = m_pc;
            m_pc    = tgt & 32'hFFFF_FFFC;
            m_instr = NOP;
            m_valid = 1'b0;
        end else begin
            if (le) begin
                m_instr = imem_word(m_pc);
                m_id_pc = m_pc;
                m_valid = 1'b1;
                m_count = m_count + 32'd1;
            end
            if (pe) m_pc = m_pc + 32'd4;
        end
        e = '{pc: m_pc, instr: m_instr, id_pc: m_id_pc, valid: m_valid, count: m_count};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        check_val("pc", imem_addr, o.pc);
        check_val("instr", if_id_instruction, o.instr);
        check_val("id_pc", if_id_pc, o.id_pc);
        check_val("valid", {31'b0, if_id_valid}, {31'b0, o.valid});
        check_val("count", fetch_count, o.count);
        $display("step pe=%0b le=%0b rd=%0b tgt=%08h -> pc=%08h instr=%08h id_pc=%08h v=%0b cnt=%0d",
                 pe, le, rd, tgt, imem_addr, if_id_instruction, if_id_pc, if_id_valid, fetch_count);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_pc"}, imem_addr, 32'h0);
        check_val({tag, "_instr"}, if_id_instruction, NOP);
        check_val({tag, "_id_pc"}, if_id_pc, 32'h0);
        check_val({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        check_val({tag, "_count"}, fetch_count, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; pc_enable = 1'b1; load_enable = 1'b1; redirect = 1'b0; redirect_target = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_val("boot_addr", imem_addr, 32'h0);
        check_val("boot_valid", {31'b0, if_id_valid}, 32'h0);
        // BOOT edge: nothing moves even with enables high
        @(posedge clk);
        #1;
        check_reset_vals("boot");
        $display("boot edge: pc=%08h v=%0b", imem_addr, if_id_valid);

        m_pc = 32'h0; m_instr = NOP; m_id_pc = 32'h0; m_valid = 1'b0; m_count = 32'h0;

        step(1, 1, 0, 0);
        check_val("first_instr", if_id_instruction, 32'h00A0_0093);
        check_val("first_addr", imem_addr, 32'h4);
        step(1, 1, 0, 0);                       // pc -> 8
        step(0, 0, 0, 0);                       // load-use stall at pc=8
        check_val("stall_pc", imem_addr, 32'h8);
        check_val("stall_id_pc", if_id_pc, 32'h4);
        step(1, 1, 0, 0);                       // captures pc=8 word
        check_val("post_stall_cnt", fetch_count, 32'd3);
        step(1, 1, 0, 0);                       // pc -> 16
        step(0, 0, 1, 32'h0000_0041);           // redirect beats stall
        check_val("redir_pc", imem_addr, 32'h40);
        check_val("redir_valid", {31'b0, if_id_valid}, 32'h0);
        step(1, 1, 0, 0);
        check_val("redir_capture_pc", if_id_pc, 32'h40);
        step(1, 0, 0, 0);                       // PC advances, word dropped
        step(1, 1, 1, 32'h0000_0100);           // consecutive redirects
        step(1, 1, 1, 32'hFFFF_FFFE);
        check_val("wrap_target", imem_addr, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        check_val("wrap_pc", imem_addr, 32'h0);
        check_val("wrap_id_pc", if_id_pc, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 5) == 0), $urandom);
        end

        // async reset between edges while stalled
        @(negedge clk);
        pc_enable = 1'b0; load_enable = 1'b0; redirect = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async");
        $display("async reset: pc=%08h v=%0b cnt=%0d", imem_addr, if_id_valid, fetch_count);
        @(posedge clk);
        #1;
        check_reset_vals("held");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
